// File: rtl/xsleenacore_obj_linebuf.sv
// xsleenacore_obj_linebuf
// Double-buffered sprite line buffer feeding the video mixer. The renderer
// draws the next scanline into bank `sel` through a read-modify-write port
// (first opaque pixel wins, transparent pixels never land) while the bank
// ~sel is scanned out at pixel rate and erased behind the read pointer.
// Banks swap on LINE_START. After reset, both banks are swept to zero.
//
// Ports:
//   clk        system clock, everything on posedge
//   RSTn       asynchronous active-low reset
//   HCLKn      one-clk-wide pixel enable
//   HBLKn      active-low horizontal blank (high = active display)
//   LINE_START one-cycle scanline start pulse, swaps banks
//   WR_EN      renderer write request, held until accepted
//   WR_X       target pixel X of the write
//   WR_COL     colour {palette[2:0], colour[3:0]}, colour==0 is transparent
//   WR_READY   write accept; a transfer happens when WR_EN && WR_READY
//   OBJCOL     object colour for the current pixel, two clk after HCLKn
//   CLR_BUSY   high while the post-reset clear sweep runs
module xsleenacore_obj_linebuf #(
    parameter int X_W   = 8,
    parameter int COL_W = 7
) (
    input  logic             clk,
    input  logic             RSTn,
    input  logic             HCLKn,
    input  logic             HBLKn,
    input  logic             LINE_START,
    input  logic             WR_EN,
    input  logic [X_W-1:0]   WR_X,
    input  logic [COL_W-1:0] WR_COL,
    output logic             WR_READY,
    output logic [COL_W-1:0] OBJCOL,
    output logic             CLR_BUSY
);

    localparam int DEPTH = 1 << X_W;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        RMW   = 2'd2
    } state_t;

    state_t state, state_next;

    logic [COL_W-1:0] bank_a [DEPTH];
    logic [COL_W-1:0] bank_b [DEPTH];

    logic             sel;
    logic [X_W-1:0]   rd_x;
    logic [X_W-1:0]   clr_x;

    logic [X_W-1:0]   wr_x_p0;
    logic [COL_W-1:0] wr_col_p0;
    logic [COL_W-1:0] old_col_p0;
    logic             wr_bank_p0;

    logic             vld_p0;
    logic [COL_W-1:0] pix_p0;

    logic             running;
    logic             pix_step;
    logic             rd_step;
    logic             accept;
    logic             commit;

    function automatic logic opaque(input logic [COL_W-1:0] c);
        return c[3:0] != 4'd0;
    endfunction

    assign WR_READY = (state == IDLE);
    assign CLR_BUSY = (state == CLEAR);

    // A blanked pixel still advances the output pipeline (it forces OBJCOL
    // to zero) but neither reads, erases nor moves rd_x.
    always_comb begin
        running  = (state != CLEAR);
        pix_step = running && HCLKn && !LINE_START;
        rd_step  = pix_step && HBLKn;
        accept   = (state == IDLE) && WR_EN;
        commit   = (state == RMW) && opaque(wr_col_p0) && !opaque(old_col_p0);
    end

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:   if (clr_x == {X_W{1'b1}}) state_next = IDLE;
            IDLE:    if (WR_EN) state_next = RMW;
            RMW:     state_next = IDLE;
            default: state_next = CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state  <= CLEAR;
            clr_x  <= '0;
            sel    <= 1'b0;
            rd_x   <= '0;
            vld_p0 <= 1'b0;
            OBJCOL <= '0;
        end else begin
            state <= state_next;
            if (state == CLEAR) clr_x <= clr_x + 1'b1;
            if (running && LINE_START) begin
                sel  <= ~sel;
                rd_x <= '0;
            end else if (rd_step) begin
                rd_x <= rd_x + 1'b1;
            end
            // stage p0 -> p1: registered bank data becomes the mixer output
            vld_p0 <= pix_step;
            if (vld_p0) OBJCOL <= pix_p0;
        end
    end

    // Datapath and storage. The erase is written after the commit so that
    // an in-flight commit landing on the just-swapped scan bank at the
    // address being erased loses to the erase.
    always_ff @(posedge clk) begin
        // stage p0: accept latches the write and reads the target entry
        if (accept) begin
            wr_x_p0    <= WR_X;
            wr_col_p0  <= WR_COL;
            wr_bank_p0 <= sel;
            old_col_p0 <= sel ? bank_b[WR_X] : bank_a[WR_X];
        end
        if (pix_step) begin
            if (rd_step) pix_p0 <= sel ? bank_a[rd_x] : bank_b[rd_x];
            else         pix_p0 <= '0;
        end

        if (state == CLEAR) begin
            bank_a[clr_x] <= '0;
            bank_b[clr_x] <= '0;
        end else begin
            if (commit) begin
                if (wr_bank_p0) bank_b[wr_x_p0] <= wr_col_p0;
                else            bank_a[wr_x_p0] <= wr_col_p0;
            end
            if (rd_step) begin
                if (sel) bank_a[rd_x] <= '0;
                else     bank_b[rd_x] <= '0;
            end
        end
    end

endmodule

// File: doc/xsleenacore_obj_linebuf.md
# xsleenacore_obj_linebuf

Double-buffered object (sprite) line buffer sitting directly upstream of the video mixer; it produces the per-pixel `OBJCOL` value the mixer prioritises against the map and background layers. While one bank is scanned out at pixel rate, the sprite renderer draws the next scanline into the other bank. Banks swap at each line start. The scanned bank is erased behind the read pointer, so it is clean when it becomes the draw bank.

## Interface
Parameters:
- `X_W`, 8: pixel X address width; each bank holds 2^X_W entries.
- `COL_W`, 7: colour width, {palette[2:0], colour[3:0]}. colour[3:0]==0 is transparent.

Ports:
- `clk`  in  1  single system clock, all logic on posedge.
- `RSTn`  in  1  asynchronous active-low reset.
- `HCLKn`  in  1  pixel clock enable, one `clk`-wide pulse per pixel (active high, same usage as the mixer's enable).
- `HBLKn`  in  1  active-low horizontal blank; high = active display.
- `LINE_START`  in  1  one-cycle pulse at the start of each scanline; swaps banks.
- `WR_EN`  in  1  renderer write request (valid), held until accepted.
- `WR_X`  in  X_W  target X of the write.
- `WR_COL`  in  COL_W  colour to write.
- `WR_READY`  out  1  write accept; the transfer occurs when WR_EN && WR_READY.
- `OBJCOL`  out  COL_W  object colour for the current pixel, to the mixer.
- `CLR_BUSY`  out  1  high during the post-reset clear sweep.

## Operation
- Storage: two banks, A and B, each 2^X_W x COL_W, with synchronous read. Register `sel`: the renderer writes bank `sel` and the reader scans bank `~sel`.
- FSM states: CLEAR, IDLE, RMW.
  - CLEAR: entered on reset. A counter `clr_x` runs 0..2^X_W-1 and writes 0 to both banks at `clr_x` every cycle. After the last address the FSM goes to IDLE. `CLR_BUSY`=1 and `WR_READY`=0 in CLEAR. `LINE_START` and `HCLKn` are ignored and `OBJCOL` stays 0.
  - IDLE: `WR_READY`=1. On WR_EN && WR_READY, latch X, COL and bank=`sel`, issue the read of the latched bank at X, then go to RMW.
  - RMW: `WR_READY`=0. The entry read back is compared:
    - The write is committed only if WR_COL[3:0]!=0 and the existing entry[3:0]==0.
    - Result: first-drawn sprite wins and transparent pixels never overwrite.
    - The FSM always returns to IDLE.
  - Throughput: one accepted write every 2 cycles.
- Reader: counter `rd_x`.
  - On each cycle with `HCLKn`=1, `HBLKn`=1 and no `LINE_START`: read bank `~sel` at `rd_x`, write 0 to the same location (erase-behind), then `rd_x`++.
  - `rd_x` wraps modulo 2^X_W.
  - When `HBLKn`=0: no read, no erase, `rd_x` holds, `OBJCOL` is forced to 0 on the next HCLKn.
- `LINE_START` (outside CLEAR): `sel` <= ~`sel`, `rd_x` <= 0. No read or erase occurs in that cycle.
- Boundary and simultaneous events:
  - WR_EN accepted in the same cycle as `LINE_START`: targets the pre-toggle `sel`.
  - An RMW in flight across a swap commits to its latched bank.
  - If that commit hits the same bank address as a reader erase in the same cycle, the erase wins.
  - Writes while WR_READY=0 are not accepted; the renderer holds its request.
  - Reset asserted mid-operation aborts any RMW and restarts CLEAR.

## Timing
- Reset values:
  - `OBJCOL`=0, `WR_READY`=0, `CLR_BUSY`=1.
  - `sel`=0, `rd_x`=0, `clr_x`=0, FSM=CLEAR.
- CLEAR lasts exactly 2^X_W cycles after RSTn deassertion. `WR_READY` rises on cycle 2^X_W+1.
- Read latency: bank data is registered, and `OBJCOL` updates on the `clk` edge after the cycle following the HCLKn pulse. That is 2 `clk` of latency, stable until the next update.
- Write: accept in cycle N, commit decision at the end of cycle N+1, `WR_READY`=1 again in cycle N+2.
- `WR_READY` is a registered FSM decode with no combinational path from WR_EN.

## Test plan
- Reset: release RSTn, then `CLR_BUSY`=1 for 256 cycles and `WR_READY` high at cycle 257. Scan a line: `OBJCOL`=0 at all 256 pixels.
- Basic draw/scan:
  - Write X=5 COL=7'h23, X=255 COL=7'h7F, then pulse LINE_START and scan.
  - `OBJCOL`=7'h23 at pixel 5 and 7'h7F at pixel 255, 0 elsewhere.
  - On the next line after a second swap, the same bank reads all 0 (erase-behind).
- Priority and transparency: write X=10 7'h11, then X=10 7'h25, then X=11 7'h30. Scan gives pixel 10=7'h11 and pixel 11=0.
- Handshake: hold WR_EN continuously with 4 writes. Exactly 4 accepts occur on alternate cycles, and WR_READY pattern is 1,0,1,0.
- Swap collision: accept a write in the same cycle as LINE_START. The data appears in the line scanned after that LINE_START, not one line later.
- Blank and wrap: HBLKn=0 for 20 HCLKn pulses mid-line. `rd_x` holds, `OBJCOL`=0, and the bank contents are intact after the resume. 300 active pixels wrap `rd_x` 255->0.
